mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Arbitrates the single-port external memory between the CPU datapath (MAR/MBR accesses sequenced by the control unit) and the host loader/debug port. It serialises requests, enforces fixed memory latency and returns read data with a one-cycle done pulse. It also drives a stall to the control unit so the micro-sequencer holds while a CPU access is outstanding.

## Interface
- ADDR_W, 8, memory address width
- DATA_W, 16, memory data width
- MEM_LATENCY, 2, cycles from the memory-enable cycle to valid read data; legal 1..8
- i_clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_cpu_req / i_host_req  in  1  access request, per requester
- i_cpu_we / i_host_we  in  1  1 = write, 0 = read
- i_cpu_addr / i_host_addr  in  ADDR_W  access address
- i_cpu_wdata / i_host_wdata  in  DATA_W  write data
- i_host_lock  in  1  loader mode: CPU never granted while high
- o_cpu_done / o_host_done  out  1  one-cycle completion pulse
- o_rdata  out  DATA_W  read data, valid during done pulse, held until next capture
- o_cpu_stall  out  1  to CU: CPU request pending or in flight
- o_busy  out  1  transaction in flight (state != IDLE)
- o_mem_en, o_mem_we  out  1  memory strobe / write enable
- o_mem_addr, o_mem_wdata  out  ADDR_W / DATA_W  memory address / write data
- i_mem_rdata  in  DATA_W  memory read data

## Operation
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE: eligible = i_host_req, plus i_cpu_req when i_host_lock=0. None eligible -> stay. One eligible -> grant it. Both eligible -> grant the requester not granted last (round robin); last_grant resets to HOST, so the CPU wins the first tie. On grant: latch owner, we, addr, wdata; go to ACCESS.
- ACCESS (exactly 1 cycle): o_mem_en=1, o_mem_we=latched we, o_mem_addr/o_mem_wdata = latched values. Load wait counter with MEM_LATENCY; go to WAIT.
- WAIT: decrement counter each cycle; o_mem_en=0. In the cycle the counter reaches 1, capture i_mem_rdata into o_rdata (reads only; writes leave o_rdata unchanged) and go to DONE.
- DONE (1 cycle): owner's done pulse = 1; update last_grant = owner; go to IDLE.
- Request fields are sampled only at grant. Later changes are ignored and the transaction always completes. Dropping req before grant withdraws it.
- A requester must deassert req in the cycle after its done pulse, or a new transaction is issued. req held high through IDLE = intentional back-to-back access.
- i_host_lock rising during a CPU transaction does not abort it; it only blocks later CPU grants.
- o_cpu_stall = i_cpu_req & ~o_cpu_done (combinational). It stays high while the CPU is locked out.
- o_mem_addr/o_mem_wdata hold latched values outside ACCESS. o_mem_we is 0 whenever o_mem_en=0.

## Timing
- Reset (async assert, any state): state=IDLE, last_grant=HOST, counter=0, o_rdata=0. All registered outputs (done pulses, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_busy) are 0. Any in-flight transaction is abandoned with no done pulse.
- Request sampled high at end of IDLE cycle T:
  - ACCESS at T+1.
  - WAIT at T+2..T+1+MEM_LATENCY; read data captured at end of T+1+MEM_LATENCY.
  - Done pulse at T+2+MEM_LATENCY, so latency is MEM_LATENCY+2 cycles.
- Reads and writes have identical timing.
- Minimum spacing between back-to-back grants: MEM_LATENCY+3 cycles (IDLE cycle included).
- o_busy=1 in ACCESS, WAIT and DONE.

## Test plan
- MEM_LATENCY=2, CPU read at addr 0x10 (memory 0x10=0xBEEF), req at cycle 5: o_mem_en only at cycle 6; o_cpu_done and o_rdata=0xBEEF at cycle 9; o_cpu_stall high cycles 5..8.
- Host write 0x1234 to 0x20, then CPU read 0x20: write strobe has o_mem_we=1; CPU read returns 0x1234.
- Both req high together at cycle 0 after reset, both held: CPU served first, host next. With continued requests, grants alternate CPU, HOST, CPU, HOST.
- i_host_lock=1 with CPU and host both requesting: only host grants; o_cpu_stall stays 1. Release lock: CPU granted at the next IDLE.
- Change i_cpu_addr and drop i_cpu_req during WAIT: access completes at the original address and the done pulse still fires.
- Assert i_rst_n=0 mid-WAIT: all outputs 0 immediately, no done pulse. After release, a tie grants CPU first.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin CPU/host arbiter for a single-port memory with fixed read latency.
module mem_bus_arbiter #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int MEM_LATENCY = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    input  logic              i_host_req,
    input  logic              i_host_we,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [DATA_W-1:0] i_host_wdata,
    input  logic              i_host_lock,
    output logic              o_cpu_done,
    output logic              o_host_done,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_cpu_stall,
    output logic              o_busy,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
    state_t state, state_nx;
    logic              cpu_ok, eligible, grant_cpu;
    logic              owner_cpu, we, last_cpu;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata, rdata;

    // last_cpu=0 means the host was granted last, so a tie favours the CPU
    always_comb begin
        cpu_ok    = i_cpu_req & ~i_host_lock;
        eligible  = cpu_ok | i_host_req;
        grant_cpu = cpu_ok & (~i_host_req | ~last_cpu);
        state_nx  = state == IDLE   ? (eligible ? ACCESS : IDLE) :
                    state == ACCESS ? WAIT :
                    state == WAIT   ? (cnt == 4'd1 ? DONE : WAIT) : IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nx;

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            owner_cpu <= 1'b0;
            we        <= 1'b0;
            last_cpu  <= 1'b0;
            cnt       <= 4'd0;
            addr      <= '0;
            wdata     <= '0;
            rdata     <= '0;
        end else begin
            if (state == IDLE && eligible) begin
                owner_cpu <= grant_cpu;
                we        <= grant_cpu ? i_cpu_we    : i_host_we;
                addr      <= grant_cpu ? i_cpu_addr  : i_host_addr;
                wdata     <= grant_cpu ? i_cpu_wdata : i_host_wdata;
            end
            if (state == ACCESS)    cnt <= 4'(MEM_LATENCY);
            else if (state == WAIT) cnt <= cnt - 4'd1;
            if (state == WAIT && cnt == 4'd1 && !we) rdata <= i_mem_rdata;
            if (state == DONE) last_cpu <= owner_cpu;
        end

    assign o_mem_en    = state == ACCESS;
    assign o_mem_we    = o_mem_en & we;
    assign o_busy      = state != IDLE;
    assign o_cpu_done  = state == DONE && owner_cpu;
    assign o_host_done = state == DONE && !owner_cpu;
    assign o_mem_addr  = addr;
    assign o_mem_wdata = wdata;
    assign o_rdata     = rdata;
    assign o_cpu_stall = i_cpu_req & ~o_cpu_done;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenarios plus random traffic against a transaction-timing model.
module tb_mem_bus_arbiter;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int L  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_cpu_req, i_cpu_we, i_host_req, i_host_we, i_host_lock;
    logic [AW-1:0] i_cpu_addr, i_host_addr;
    logic [DW-1:0] i_cpu_wdata, i_host_wdata, i_mem_rdata;
    logic          o_cpu_done, o_host_done, o_cpu_stall, o_busy, o_mem_en, o_mem_we;
    logic [DW-1:0] o_rdata, o_mem_wdata;
    logic [AW-1:0] o_mem_addr;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(L)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cpu_req(i_cpu_req), .i_cpu_we(i_cpu_we), .i_cpu_addr(i_cpu_addr), .i_cpu_wdata(i_cpu_wdata),
        .i_host_req(i_host_req), .i_host_we(i_host_we), .i_host_addr(i_host_addr), .i_host_wdata(i_host_wdata),
        .i_host_lock(i_host_lock), .o_cpu_done(o_cpu_done), .o_host_done(o_host_done), .o_rdata(o_rdata),
        .o_cpu_stall(o_cpu_stall), .o_busy(o_busy), .o_mem_en(o_mem_en), .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
    );

    int pass_cnt = 0;
    int tot_cnt  = 0;
    int cyc      = 0;
    int rd_due   = -100;
    logic [DW-1:0] rd_val;
    logic [DW-1:0] bus_mem   [256];
    logic [DW-1:0] model_mem [256];

    // transaction model: one outstanding access, timed by its phase from the ACCESS cycle
    logic          m_busy, m_owner, m_we, m_last;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    int            m_a;

    logic          s_en, s_we, s_cdone, s_hdone, s_stall;
    logic [DW-1:0] s_rdata;
    logic [AW-1:0] s_addr;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        tot_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s cyc=%0d got=%0h exp=%0h", n, cyc, got, exp);
    endtask

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_we = 0; m_last = 0;
        m_addr = '0; m_wdata = '0; m_rdata = '0; m_a = 0;
        rd_due = -100;
    endtask

    task automatic tick();
        int   ph;
        logic e_en, e_cd, e_hd, ce, he;
        i_mem_rdata = (cyc == rd_due) ? rd_val : DW'($urandom);
        #1;
        ph   = cyc - m_a;
        e_en = m_busy && ph == 0;
        e_cd = m_busy && ph == L + 1 && m_owner;
        e_hd = m_busy && ph == L + 1 && !m_owner;
        chk("mem_en",    32'(o_mem_en),    32'(e_en));
        chk("mem_we",    32'(o_mem_we),    32'(e_en && m_we));
        chk("busy",      32'(o_busy),      32'(m_busy));
        chk("cpu_done",  32'(o_cpu_done),  32'(e_cd));
        chk("host_done", 32'(o_host_done), 32'(e_hd));
        chk("stall",     32'(o_cpu_stall), 32'(i_cpu_req && !e_cd));
        chk("mem_addr",  32'(o_mem_addr),  32'(m_addr));
        chk("mem_wdata", 32'(o_mem_wdata), 32'(m_wdata));
        chk("rdata",     32'(o_rdata),     32'(m_rdata));
        s_en = o_mem_en; s_we = o_mem_we; s_cdone = o_cpu_done; s_hdone = o_host_done;
        s_stall = o_cpu_stall; s_rdata = o_rdata; s_addr = o_mem_addr;
        if (o_mem_en) begin
            if (o_mem_we) bus_mem[o_mem_addr] = o_mem_wdata;
            else begin
                rd_due = cyc + L;
                rd_val = bus_mem[o_mem_addr];
            end
        end
        if (rst_n) begin
            if (!m_busy) begin
                ce = i_cpu_req && !i_host_lock;
                he = i_host_req;
                if (ce || he) begin
                    m_owner = (ce && he) ? !m_last : ce;
                    m_we    = m_owner ? i_cpu_we    : i_host_we;
                    m_addr  = m_owner ? i_cpu_addr  : i_host_addr;
                    m_wdata = m_owner ? i_cpu_wdata : i_host_wdata;
                    m_busy  = 1;
                    m_a     = cyc + 1;
                end
            end else begin
                if (ph == 0 && m_we)  model_mem[m_addr] = m_wdata;
                if (ph == L && !m_we) m_rdata = model_mem[m_addr];
                if (ph == L + 1) begin
                    m_busy = 0;
                    m_last = m_owner;
                end
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_en",    32'(o_mem_en),    32'd0);
        chk("rst_we",    32'(o_mem_we),    32'd0);
        chk("rst_busy",  32'(o_busy),      32'd0);
        chk("rst_cdone", 32'(o_cpu_done),  32'd0);
        chk("rst_hdone", 32'(o_host_done), 32'd0);
        chk("rst_rdata", 32'(o_rdata),     32'd0);
        chk("rst_addr",  32'(o_mem_addr),  32'd0);
        chk("rst_wdata", 32'(o_mem_wdata), 32'd0);
        model_reset();
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic wait_done(output logic cpu_d, output logic we_en);
        cpu_d = 0;
        we_en = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (s_en) we_en = s_we;
            if (s_cdone || s_hdone) begin
                cpu_d = s_cdone;
                return;
            end
        end
        tot_cnt++;
        $display("FAIL done_timeout cyc=%0d got=none exp=done", cyc);
    endtask

    task automatic wait_en();
        for (int k = 0; k < 20; k++) begin
            tick();
            if (s_en) return;
        end
        tot_cnt++;
        $display("FAIL en_timeout cyc=%0d got=none exp=mem_en", cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=hang exp=finish", cyc);
        $fatal(1);
    end

    initial begin
        logic cd, we_en;
        logic exp_o [4];
        exp_o = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 256; i++) begin
            bus_mem[i]   = DW'($urandom);
            model_mem[i] = bus_mem[i];
        end
        bus_mem[8'h10] = 16'hBEEF; model_mem[8'h10] = 16'hBEEF;
        bus_mem[8'h30] = 16'hCAFE; model_mem[8'h30] = 16'hCAFE;
        bus_mem[8'h31] = 16'h0BAD; model_mem[8'h31] = 16'h0BAD;
        rst_n = 1'b1;
        {i_cpu_req, i_cpu_we, i_host_req, i_host_we, i_host_lock} = '0;
        i_cpu_addr = '0; i_host_addr = '0; i_cpu_wdata = '0; i_host_wdata = '0; i_mem_rdata = '0;
        #2;
        do_reset();

        // CPU read at 0x10 requested in cycle 5
        i_cpu_addr = 8'h10;
        for (int c = 0; c < 13; c++) begin
            i_cpu_req = c >= 5 && c <= 9;
            tick();
            chk("t1_en",   32'(s_en),    32'(c == 6));
            chk("t1_done", 32'(s_cdone), 32'(c == 9));
            if (c == 9) chk("t1_rdata", 32'(s_rdata), 32'hBEEF);
            if (c >= 5 && c <= 8) chk("t1_stall", 32'(s_stall), 32'd1);
        end

        // host write then CPU read-back
        i_host_req = 1; i_host_we = 1; i_host_addr = 8'h20; i_host_wdata = 16'h1234;
        wait_done(cd, we_en);
        chk("t2_host_owner", 32'(cd), 32'd0);
        chk("t2_we", 32'(we_en), 32'd1);
        i_host_req = 0; i_cpu_req = 1; i_cpu_we = 0; i_cpu_addr = 8'h20;
        wait_done(cd, we_en);
        chk("t2_cpu_owner", 32'(cd), 32'd1);
        chk("t2_rdata", 32'(s_rdata), 32'h1234);
        i_cpu_req = 0;

        // tie right after reset, both held: CPU, HOST, CPU, HOST
        i_cpu_req = 1; i_host_req = 1; i_host_we = 0; i_host_addr = 8'h05; i_cpu_addr = 8'h06;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wait_done(cd, we_en);
            chk("t3_order", 32'(cd), 32'(exp_o[i]));
        end

        // lockout: host only, stall stays up; release gives CPU the next grant
        i_host_lock = 1;
        for (int i = 0; i < 3; i++) begin
            wait_done(cd, we_en);
            chk("t4_locked_owner", 32'(cd), 32'd0);
            chk("t4_stall", 32'(s_stall), 32'd1);
        end
        i_host_lock = 0;
        wait_done(cd, we_en);
        chk("t4_release_owner", 32'(cd), 32'd1);
        i_cpu_req = 0; i_host_req = 0;
        tick();

        // request fields change and req drops during WAIT
        i_cpu_req = 1; i_cpu_we = 0; i_cpu_addr = 8'h30;
        wait_en();
        i_cpu_req = 0; i_cpu_addr = 8'h31;
        wait_done(cd, we_en);
        chk("t5_owner", 32'(cd), 32'd1);
        chk("t5_rdata", 32'(s_rdata), 32'hCAFE);
        chk("t5_addr",  32'(s_addr),  32'h30);

        // reset mid-WAIT, then a tie goes to the CPU
        i_host_req = 1; i_host_we = 0; i_host_addr = 8'h40;
        wait_en();
        i_cpu_req = 1;
        do_reset();
        wait_done(cd, we_en);
        chk("t6_owner", 32'(cd), 32'd1);
        i_cpu_req = 0; i_host_req = 0;

        for (int n = 0; n < 3000; n++) begin
            if (!i_cpu_req) begin
                if ($urandom % 4 == 0) begin
                    i_cpu_req = 1; i_cpu_we = 1'($urandom);
                    i_cpu_addr = AW'($urandom % 16); i_cpu_wdata = DW'($urandom);
                end
            end else if ($urandom % 12 == 0) i_cpu_req = 0;
            else if ($urandom % 16 == 0) begin
                i_cpu_we = 1'($urandom); i_cpu_addr = AW'($urandom % 16); i_cpu_wdata = DW'($urandom);
            end
            if (!i_host_req) begin
                if ($urandom % 4 == 0) begin
                    i_host_req = 1; i_host_we = 1'($urandom);
                    i_host_addr = AW'($urandom % 16); i_host_wdata = DW'($urandom);
                end
            end else if ($urandom % 12 == 0) i_host_req = 0;
            else if ($urandom % 16 == 0) begin
                i_host_we = 1'($urandom); i_host_addr = AW'($urandom % 16); i_host_wdata = DW'($urandom);
            end
            if ($urandom % 40 == 0) i_host_lock = ~i_host_lock;
            if ($urandom % 700 == 0) do_reset();
            else tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
